// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - RV32I data-memory load/store request/ack controller
// Optional: MEM_MISALIGN_TRAP_EN rejects misaligned accesses instead of force-aligning them.
module mem_access_unit #(
    parameter int TIMEOUT = 15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_storeData,
    output logic        o_stall,
    output logic [31:0] o_loadData,
    output logic        o_loadValid,
    output logic        o_busErr,
    output logic        o_misaligned,
    output logic        o_memReq,
    output logic        o_memWe,
    output logic [31:0] o_memAddr,
    output logic [3:0]  o_memByteEn,
    output logic [31:0] o_memWData,
    input  logic [31:0] i_memRData,
    input  logic        i_memAck
);
    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        is_load, is_store, mem_op, stall_raw;
    logic [1:0]  size, off_eff;
    logic [3:0]  be_d, be_q;
    logic [31:0] wdata_d, wdata_q, addr_q, ldata_q, ldata_d, shifted;
    logic [1:0]  size_q, off_q;
    logic        we_q, uns_q, load_q, err_q;
    logic [7:0]  cnt_q;
    logic        unused_ok;

    assign is_load   = i_opcode[6:2] == 5'b00000;
    assign is_store  = i_opcode[6:2] == 5'b01000;
    assign mem_op    = is_load | is_store;
    assign size      = i_funct3[1:0];
    assign unused_ok = &{1'b0, i_opcode[1:0]};

    // Effective lane offset: misaligned halves/words drop the offending low address bits.
    always_comb begin
        off_eff = 2'b00;
        be_d    = 4'b1111;
        wdata_d = i_storeData;
        case (size)
            2'b00: begin
                off_eff = i_addr[1:0];
                be_d    = 4'b0001 << i_addr[1:0];
                wdata_d = {4{i_storeData[7:0]}};
            end
            2'b01: begin
                off_eff = {i_addr[1], 1'b0};
                be_d    = 4'b0011 << {i_addr[1], 1'b0};
                wdata_d = {2{i_storeData[15:0]}};
            end
            default: begin
                off_eff = 2'b00;
                be_d    = 4'b1111;
                wdata_d = i_storeData;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic misaligned, mis_q;
    assign misaligned = (size == 2'b01 && i_addr[0]) || (size[1] && i_addr[1:0] != 2'b00);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mis_q <= 1'b0;
        end else if (state_q == S_IDLE && mem_op) begin
            mis_q <= misaligned;
        end
    end

    assign o_misaligned = (state_q == S_DONE) && mis_q;
`else
    logic mis_q;
    assign mis_q        = 1'b0;
    assign o_misaligned = 1'b0;
`endif

    assign shifted = i_memRData >> {off_q, 3'b000};

    always_comb begin
        ldata_d = i_memRData;
        case (size_q)
            2'b00:   ldata_d = uns_q ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   ldata_d = uns_q ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: ldata_d = i_memRData;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        stall_raw = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (mem_op) begin
                    stall_raw = 1'b1;
                    state_d   = S_REQ;
`ifdef MEM_MISALIGN_TRAP_EN
                    if (misaligned) state_d = S_DONE;
`endif
                end
            end
            S_REQ: begin
                stall_raw = 1'b1;
                if (i_memAck || cnt_q == TO_LAST) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            size_q  <= 2'b00;
            off_q   <= 2'b00;
            uns_q   <= 1'b0;
            load_q  <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'h0;
            ldata_q <= 32'h0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (mem_op) begin
                        we_q    <= is_store;
                        addr_q  <= {i_addr[31:2], 2'b00};
                        be_q    <= be_d;
                        wdata_q <= wdata_d;
                        size_q  <= size;
                        off_q   <= off_eff;
                        uns_q   <= i_funct3[2];
                        load_q  <= is_load;
                        err_q   <= 1'b0;
                        cnt_q   <= 8'h0;
                    end
                end
                S_REQ: begin
                    // Ack takes priority over the final timeout cycle.
                    if (i_memAck) begin
                        ldata_q <= ldata_d;
                    end else if (cnt_q == TO_LAST) begin
                        err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_stall     = i_rst_n && stall_raw;
    assign o_memReq    = state_q == S_REQ;
    assign o_memWe     = o_memReq && we_q;
    assign o_memAddr   = addr_q;
    assign o_memByteEn = be_q;
    assign o_memWData  = wdata_q;
    assign o_loadData  = ldata_q;
    assign o_loadValid = (state_q == S_DONE) && load_q && !err_q && !mis_q;
    assign o_busErr    = (state_q == S_DONE) && err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb/tb_mem_access_unit.sv - scoreboard bench for mem_access_unit with a behavioural memory model
module tb_mem_access_unit;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  opcode = 7'b0110011;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] sdata = 32'h0;
    logic [31:0] rdata = 32'h0;
    logic        ack = 1'b0;
    logic        stall, load_valid, bus_err, misal, mem_req, mem_we;
    logic [31:0] load_data, mem_addr, mem_wdata;
    logic [3:0]  mem_be;

    mem_access_unit #(.TIMEOUT(TIMEOUT)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_opcode(opcode), .i_funct3(funct3),
        .i_addr(addr), .i_storeData(sdata), .o_stall(stall), .o_loadData(load_data),
        .o_loadValid(load_valid), .o_busErr(bus_err), .o_misaligned(misal),
        .o_memReq(mem_req), .o_memWe(mem_we), .o_memAddr(mem_addr),
        .o_memByteEn(mem_be), .o_memWData(mem_wdata), .i_memRData(rdata), .i_memAck(ack)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] wd;
        logic        we;
    } req_t;
    typedef struct {
        int          kind;   // 0 load data, 1 bus error, 2 misaligned
        logic [31:0] data;
    } rsp_t;

    req_t exp_req_q[$];
    rsp_t exp_rsp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cur_delay = NEVER;
    logic [31:0] cur_rdata = 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int eff_off(input logic [2:0] f3, input logic [31:0] a);
        int off = int'(a[1:0]);
        if (f3[1:0] == 2'b00) return off;
        if (f3[1:0] == 2'b01) return (off / 2) * 2;
        return 0;
    endfunction

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit is_misal(input logic [2:0] f3, input logic [31:0] a);
        return (int'(a[1:0]) % nbytes(f3)) != 0;
    endfunction

    function automatic req_t model_req(input logic [2:0] f3, input logic [31:0] a,
                                       input logic [31:0] sd, input bit st);
        req_t r;
        int off = eff_off(f3, a);
        int n = nbytes(f3);
        r.a  = a & 32'hFFFF_FFFC;
        r.we = st;
        r.be = 4'h0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) r.be[i] = 1'b1;
        r.wd = 32'h0;
        for (int i = 0; i < 4; i++) r.wd[8*i +: 8] = 8'((sd >> (8 * (i % n))) & 32'hFF);
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        int n = nbytes(f3);
        logic [31:0] v = rd >> (8 * eff_off(f3, a));
        if (n == 4) return rd;
        if (n == 1) begin
            v = v & 32'hFF;
            if (!f3[2] && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else begin
            v = v & 32'hFFFF;
            if (!f3[2] && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    // Memory responder: ack after cur_delay REQ cycles; noise on ack/rdata outside REQ.
    initial begin
        int reqc = 0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_req) begin
                ack   = (reqc == cur_delay);
                rdata = ack ? cur_rdata : $urandom;
                reqc++;
            end else begin
                reqc  = 0;
                ack   = 1'($urandom_range(0, 1));
                rdata = $urandom;
            end
        end
    end

    // Monitor: compares request fields and result strobes against the scoreboard queues.
    initial begin
        logic prev_req = 1'b0;
        req_t cur;
        rsp_t r;
        cur = '{a: 32'h0, be: 4'h0, wd: 32'h0, we: 1'b0};
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_req = 1'b0;
            end else begin
                if (mem_req && !prev_req) begin
                    if (exp_req_q.size() == 0) begin
                        check("unexpected_req", 32'(mem_req), 32'h0);
                    end else begin
                        cur = exp_req_q.pop_front();
                        check("req_addr", mem_addr, cur.a);
                        check("req_byteen", 32'(mem_be), 32'(cur.be));
                        check("req_wdata", mem_wdata, cur.wd);
                        check("req_we", 32'(mem_we), 32'(cur.we));
                    end
                end else if (mem_req) begin
                    check("req_hold", {mem_addr[31:2], mem_be[1:0]} ^ mem_wdata ^ 32'(mem_we),
                          {cur.a[31:2], cur.be[1:0]} ^ cur.wd ^ 32'(cur.we));
                end
                if (load_valid || bus_err || misal) begin
                    if (exp_rsp_q.size() == 0) begin
                        check("unexpected_strobe", {29'h0, misal, bus_err, load_valid}, 32'h0);
                    end else begin
                        r = exp_rsp_q.pop_front();
                        check("rsp_kind", {29'h0, misal, bus_err, load_valid},
                              32'(1 << r.kind));
                        if (r.kind == 0) check("load_data", load_data, r.data);
                    end
                end
                prev_req = mem_req;
            end
        end
    end

    // Issue one instruction at posedge+1, return at posedge+1 after its DONE cycle.
    task automatic do_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] sd, input logic [31:0] rd, input int delay);
        bit ld = (op[6:2] == 5'b00000);
        bit st = (op[6:2] == 5'b01000);
        int exp_stall = 0;
        bit exp_lv = 1'b0;
        bit exp_err = 1'b0;
        int stalls = 0;
        bit done = 1'b0;
        if (ld || st) begin
            if (TRAP && is_misal(f3, a)) begin
                exp_stall = 1;
                exp_rsp_q.push_back('{kind: 2, data: 32'h0});
            end else begin
                exp_req_q.push_back(model_req(f3, a, sd, st));
                if (delay < TIMEOUT) begin
                    exp_stall = 2 + delay;
                    exp_lv = ld;
                    if (ld) exp_rsp_q.push_back('{kind: 0, data: model_load(f3, a, rd)});
                end else begin
                    exp_stall = 1 + TIMEOUT;
                    exp_err = 1'b1;
                    exp_rsp_q.push_back('{kind: 1, data: 32'h0});
                end
            end
        end
        cur_delay = delay;
        cur_rdata = rd;
        opcode = op; funct3 = f3; addr = a; sdata = sd;
        while (!done) begin
            @(negedge clk);
            if (!stall) begin
                done = 1'b1;
            end else begin
                stalls++;
                if (stalls > 300) begin
                    check("done_timeout", 32'(stalls), 32'(exp_stall));
                    done = 1'b1;
                end
                @(posedge clk);
                #1;
            end
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stall));
        if (ld || st) begin
            check("done_loadvalid", 32'(load_valid), 32'(exp_lv));
            check("done_buserr", 32'(bus_err), 32'(exp_err));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [6:0] ops [5] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011};
        int dlys [8] = '{0, 0, 1, 2, 3, TIMEOUT - 1, TIMEOUT, NEVER};
        opcode = 7'b0000011;
        #12;
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_req", {30'h0, mem_req, mem_we}, 32'h0);
        check("rst_strobes", {29'h0, load_valid, bus_err, misal}, 32'h0);
        check("rst_addr", mem_addr, 32'h0);
        check("rst_be_wd", mem_wdata | 32'(mem_be), 32'h0);
        check("rst_ldata", load_data, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        opcode = 7'b0110011;
        @(posedge clk);
        #1;

        do_op(7'b0000011, 3'b000, 32'h1003, 32'h0, 32'h80AABBCC, 0);
        do_op(7'b0100011, 3'b001, 32'h2002, 32'h1234ABCD, 32'h0, 0);
        do_op(7'b0000011, 3'b101, 32'h0, 32'h0, 32'h0000F00F, 3);
        do_op(7'b0000011, 3'b010, 32'h40, 32'h0, 32'h0, NEVER);
        do_op(7'b0000011, 3'b010, 32'h1002, 32'h0, 32'h11223344, 0);
        do_op(7'b0000011, 3'b010, 32'h80, 32'h0, 32'hCAFEF00D, TIMEOUT - 1);

        // Reset asserted in the second REQ cycle of a never-acked load.
        exp_req_q.push_back(model_req(3'b010, 32'h300, 32'h0, 1'b0));
        cur_delay = NEVER;
        opcode = 7'b0000011; funct3 = 3'b010; addr = 32'h300;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_req_before_rst", 32'(mem_req), 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_drops_req", 32'(mem_req), 32'h0);
        check("rst_drops_stall", 32'(stall), 32'h0);
        opcode = 7'b0110011;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_idle", {28'h0, mem_req, stall, load_valid, bus_err}, 32'h0);
        end
        @(posedge clk); #1;

        for (int i = 0; i < 60; i++) begin
            do_op(ops[$urandom_range(0, 4)], 3'($urandom_range(0, 7)), $urandom, $urandom,
                  $urandom, dlys[$urandom_range(0, 7)]);
        end

        repeat (3) @(posedge clk);
        check("req_queue_empty", 32'(exp_req_q.size()), 32'h0);
        check("rsp_queue_empty", 32'(exp_rsp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Data-memory access controller for the multi-cycle load/store path of the RV32I core. It sits directly downstream of the load stall controller's PC-enable/register-write path and upstream of the data memory. It turns a decoded load or store into a single request/acknowledge transaction on the memory port, holds the PC stalled until the transaction completes, and returns aligned, sign- or zero-extended load data with a one-cycle write-back strobe.

## Interface
Parameters:
- TIMEOUT, 15: maximum cycles spent waiting for `i_memAck` before the access is aborted (1..255).

Ports:
- i_clk  in  1  single clock, all state on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_opcode  in  7  opcode of the instruction in execute
- i_funct3  in  3  access size and signedness
- i_addr  in  32  effective byte address from ALU
- i_storeData  in  32  rs2 value for stores
- o_stall  out  1  1 = hold PC and instruction (drives PC enable low)
- o_loadData  out  32  extended load result, valid with o_loadValid
- o_loadValid  out  1  one-cycle register-file write strobe for loads
- o_busErr  out  1  one-cycle pulse: access timed out
- o_misaligned  out  1  one-cycle pulse: misaligned access rejected (macro only)
- o_memReq  out  1  memory request, held until ack
- o_memWe  out  1  1 = write
- o_memAddr  out  32  word address: {i_addr[31:2], 2'b00}
- o_memByteEn  out  4  byte lane enables
- o_memWData  out  32  lane-replicated store data
- i_memRData  in  32  read data, valid with ack
- i_memAck  in  1  transaction complete

## Operation
- Memory op: load when `i_opcode[6:2]==5'b00000`, store when `i_opcode[6:2]==5'b01000`.
- States:
  - IDLE
    - Memory op present: `o_stall=1` (combinational); next state REQ.
    - Request fields registered on the IDLE->REQ edge.
  - REQ
    - `o_memReq=1` and all request fields held stable.
    - `i_memAck=1`: load data captured, next state DONE.
    - Wait counter reaches TIMEOUT: next state DONE with the error flag set.
  - DONE
    - `o_stall=0`; PC advances at the closing edge.
    - Strobes (`o_loadValid` for a successful load, `o_busErr` on timeout) high for this cycle only.
    - Next state IDLE.
- Size from funct3[1:0]:
  - 00 byte, byte enable `4'b0001<<addr[1:0]`.
  - 01 half, byte enable `4'b0011<<addr[1:0]`.
  - 10 and 11 word, byte enable `4'b1111`.
  - funct3[2]=1 means zero-extend; otherwise sign-extend.
- Store data: byte replicated into all four lanes; half replicated into both halves; word passed unchanged.
- Load data: `i_memRData >> (8*addr[1:0])`, then sign- or zero-extended from bit 7 or bit 15. Word loads are passed through unchanged.
- Misaligned: a half access with addr[0]=1, or a word access with addr[1:0]!=0. Handling depends on the macro (see Configuration).
- `i_memAck` is ignored in IDLE and DONE.
- Wait counter clears on entry to REQ.

## Timing
- Reset values:
  - State IDLE.
  - `o_memReq`, `o_memWe`, `o_loadValid`, `o_busErr`, `o_misaligned` = 0.
  - `o_memAddr`, `o_memByteEn`, `o_memWData`, `o_loadData` = 0.
  - `o_stall` = 0 while reset is asserted.
- Memory op decoded in cycle N:
  - REQ in N+1.
  - Ack sampled at the end of cycle N+1+k.
  - DONE in N+2+k.
  - Next instruction decoded in N+3+k.
  - Minimum occupancy with zero-wait memory: 3 cycles.
- Timeout: after TIMEOUT cycles in REQ without ack, DONE follows. `o_busErr=1`, `o_loadValid=0`.
- Ack arriving in the same cycle the counter hits TIMEOUT: ack wins; no error.
- Reset mid-REQ: `o_memReq` drops immediately (asynchronous). The transaction is abandoned and no strobe is issued.
- Non-memory opcodes: `o_stall=0` and the unit stays in IDLE.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined:
  - A misaligned access never enters REQ.
  - IDLE goes directly to DONE. `o_misaligned=1` in DONE, with no memory request and no `o_loadValid`.
- Undefined:
  - `o_misaligned` is tied to 0.
  - Misaligned accesses are issued with the offending low address bits forced to 0: addr[0] for half, addr[1:0] for word. Lanes and extraction follow the forced address.

## Test plan
- lb, addr 0x1003, rdata 0x80AABBCC, ack in the first REQ cycle:
  - `o_memByteEn=4'b1000`, `o_loadData=0xFFFFFF80`.
  - `o_loadValid` pulses in cycle N+2.
  - `o_stall` is high for cycles N and N+1 only.
- sh, addr 0x2002, storeData 0x1234ABCD: `o_memWe=1`, `o_memByteEn=4'b1100`, `o_memWData=0xABCDABCD`, no `o_loadValid`.
- lhu, addr 0x0, ack delayed 3 cycles, rdata 0x0000F00F:
  - Request fields are stable for 4 REQ cycles.
  - `o_loadData=0x0000F00F`.
  - Stall lasts 5 cycles.
- lw with ack never asserted, TIMEOUT=15: 15 REQ cycles, then `o_busErr` one-cycle pulse, `o_loadValid=0`, return to IDLE.
- lw at 0x1002:
  - With `MEM_MISALIGN_TRAP_EN`: `o_misaligned` pulses and `o_memReq` is never asserted.
  - Without it: `o_memAddr=0x1000`, `o_memByteEn=4'b1111`.
- `i_rst_n` driven low in the second REQ cycle: `o_memReq` falls before the next clock edge, and the state is IDLE after reset release with no strobes.
